pulse_receiver: RTL and testbench
=================================

PULSE_RECEIVER -- requirements
Module: pulse_receiver

Interface
REQ-001 SHALL have parameter EXP_PERIOD, default 2, meaning expected clock cycles between consecutive PULSE_IN rising edges (legal range 2..254).
REQ-002 SHALL have parameter LOCK_CNT, default 4, meaning consecutive good periods required to lock (legal range 1..15).
REQ-003 SHALL have parameter CW, default 16, meaning PULSE_CNT width.
REQ-004 SHALL have port CLK  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port RSTN  input  1  asynchronous active-low reset.
REQ-006 SHALL have port EN  input  1  receiver enable.
REQ-007 SHALL have port PULSE_IN  input  1  pulse stream, already synchronous to CLK.
REQ-008 SHALL have port CLR_ERR  input  1  clears error state and PULSE_CNT.
REQ-009 SHALL have port PULSE_SEEN  output  1  one-cycle strobe per detected rising edge.
REQ-010 SHALL have port LOCKED  output  1  high while the state machine is in SLOCK.
REQ-011 SHALL have port ERR  output  1  sticky; high while in SERR.
REQ-012 SHALL have port PULSE_CNT  output  CW  count of detected rising edges, saturating at all-ones.

Function
REQ-013 SHALL register PULSE_IN into pulse_d each cycle; rise = PULSE_IN & ~pulse_d, evaluated combinationally and acted on at the same edge.
REQ-014 SHALL keep an 8-bit gap counter: loaded with 1 at the edge following a rise, otherwise incremented, saturating at 255; at a rise cycle, gap equals the measured period.
REQ-015 SHALL implement states SIDLE, SHUNT, SACQ, SLOCK, SERR with a 4-bit good-period counter.
REQ-016 SIDLE: EN=1 -> SHUNT.
REQ-017 SHUNT: rise -> SACQ with good=0; otherwise stay.
REQ-018 SACQ: rise with gap==EXP_PERIOD -> good+1, entering SLOCK when good+1==LOCK_CNT; rise with gap!=EXP_PERIOD -> good=0 and stay; no rise -> stay.
REQ-019 SLOCK: rise with gap==EXP_PERIOD -> stay; rise with gap!=EXP_PERIOD -> SERR; no rise while gap==EXP_PERIOD (missed pulse) -> SERR.
REQ-020 SERR: stay until CLR_ERR=1, then -> SHUNT if EN=1, else SIDLE.
REQ-021 EN=0 SHALL force -> SIDLE from SHUNT, SACQ and SLOCK at the next edge and clear good; SERR ignores EN.
REQ-022 CLR_ERR SHALL take priority over rise when both occur in SERR; in other states CLR_ERR clears only PULSE_CNT.
REQ-023 PULSE_SEEN, LOCKED, ERR, PULSE_CNT SHALL be registered; PULSE_SEEN is high for exactly the cycle after a rise edge, only when EN=1 and state!=SERR.
REQ-024 PULSE_CNT SHALL increment on each counted rise (same gating as PULSE_SEEN), hold at 2^CW-1, and clear on CLR_ERR; clear wins over a simultaneous increment.

Reset
REQ-025 RSTN=0 SHALL asynchronously set state=SIDLE, pulse_d=0, gap=0, good=0, PULSE_SEEN=0, LOCKED=0, ERR=0, PULSE_CNT=0.
REQ-026 After reset release, PULSE_IN already high SHALL count as a rise on the first edge.

Configuration
REQ-027 With macro PULSE_RX_PERIOD_OUT_EN defined, an added output PERIOD [7:0] SHALL hold the gap value captured at every rise (reset 0); without the macro the port and its register are absent and behaviour is otherwise identical.

Verification
REQ-028 Defaults, EN=1, PULSE_IN toggling 0,1,0,1 (period 2) -> PULSE_SEEN every other cycle, LOCKED asserts at the edge of the 5th rise, ERR=0, PULSE_CNT=5 at lock.
REQ-029 Locked, one pulse dropped (PULSE_IN held 0 for 3 cycles) -> ERR=1 and LOCKED=0 two edges after the last rise; PULSE_CNT holds; CLR_ERR pulse -> ERR=0, PULSE_CNT=0, state SHUNT.
REQ-030 Acquiring, periods 2,2,3,2,2,2,2 -> good resets at the period-3 rise; LOCKED asserts only on the 4th good period following it.
REQ-031 Locked, EN dropped for one cycle -> LOCKED=0 next edge, no ERR; re-enable -> relock after 1+LOCK_CNT rises.
REQ-032 CW=4, 20 rises -> PULSE_CNT saturates at 15; RSTN asserted mid-stream -> all outputs 0 immediately, independent of CLK.
REQ-033 With PULSE_RX_PERIOD_OUT_EN, period-3 stream -> PERIOD=3 after each rise; build without the macro compiles with no PERIOD port.

Source files
------------

// File: rtl/pulse_receiver.sv
// Purpose : lock onto a periodic pulse stream, flag missed/misplaced pulses, count edges.
// Latency : all outputs registered; they reflect a rise or state change one edge after it is seen.
// Backpressure: none; free-running receiver, EN gates acquisition and CLR_ERR recovers from SERR.
// Optional: define PULSE_RX_PERIOD_OUT_EN to add the PERIOD output (gap captured at each rise).
module pulse_receiver #(
  parameter int unsigned EXP_PERIOD = 2,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned CW         = 16
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          EN,
  input  logic          PULSE_IN,
  input  logic          CLR_ERR,
  output logic          PULSE_SEEN,
  output logic          LOCKED,
  output logic          ERR,
`ifdef PULSE_RX_PERIOD_OUT_EN
  output logic [CW-1:0] PULSE_CNT,
  output logic [7:0]    PERIOD
`else
  output logic [CW-1:0] PULSE_CNT
`endif
);

  typedef enum logic [2:0] {SIDLE, SHUNT, SACQ, SLOCK, SERR} state_t;

  localparam logic [7:0] EXP_P  = 8'(EXP_PERIOD);
  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  state_t        state_q, state_d;
  logic [3:0]    good_q, good_d;
  logic [7:0]    gap_q, gap_d;
  logic          pulse_q;
  logic          seen_q, locked_q, err_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise;
  logic          count_en;
  logic          gap_ok;
  logic [3:0]    good_inc;

  assign rise     = PULSE_IN & ~pulse_q;
  assign count_en = rise & EN & (state_q != SERR);
  assign gap_ok   = (gap_q == EXP_P);
  assign good_inc = good_q + 4'd1;

  // Gap counter restarts at each rise so it equals the measured period on the next rise.
  always_comb begin
    gap_d = gap_q;
    if (rise)
      gap_d = 8'd1;
    else if (gap_q != 8'hFF)
      gap_d = gap_q + 8'd1;
  end

  // Edge counter: clear beats increment, increment saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR_ERR)
      cnt_d = '0;
    else if (count_en && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  // Next-state logic for the lock state machine and its good-period counter.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SIDLE: begin
        if (EN)
          state_d = SHUNT;
      end
      SHUNT: begin
        if (!EN) begin
          state_d = SIDLE;
          good_d  = 4'd0;
        end else if (rise) begin
          state_d = SACQ;
          good_d  = 4'd0;
        end
      end
      SACQ: begin
        if (!EN) begin
          state_d = SIDLE;
          good_d  = 4'd0;
        end else if (rise) begin
          if (gap_ok) begin
            good_d = good_inc;
            if (good_inc == LOCK_N)
              state_d = SLOCK;
          end else begin
            good_d = 4'd0;
          end
        end
      end
      SLOCK: begin
        if (!EN) begin
          state_d = SIDLE;
          good_d  = 4'd0;
        end else if (rise) begin
          if (!gap_ok)
            state_d = SERR;
        end else if (gap_ok) begin
          // Expected rise did not arrive on time: missed pulse.
          state_d = SERR;
        end
      end
      SERR: begin
        // CLR_ERR wins over a simultaneous rise; EN only picks the exit state.
        if (CLR_ERR) begin
          state_d = EN ? SHUNT : SIDLE;
          good_d  = 4'd0;
        end
      end
      default: begin
        state_d = SIDLE;
        good_d  = 4'd0;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= SIDLE;
      good_q   <= 4'd0;
      gap_q    <= 8'd0;
      pulse_q  <= 1'b0;
      seen_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      gap_q    <= gap_d;
      pulse_q  <= PULSE_IN;
      seen_q   <= count_en;
      locked_q <= (state_d == SLOCK);
      err_q    <= (state_d == SERR);
      cnt_q    <= cnt_d;
    end
  end

  assign PULSE_SEEN = seen_q;
  assign LOCKED     = locked_q;
  assign ERR        = err_q;
  assign PULSE_CNT  = cnt_q;

`ifdef PULSE_RX_PERIOD_OUT_EN
  logic [7:0] period_q;

  // Capture the measured period at every rise.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      period_q <= 8'd0;
    else if (rise)
      period_q <= gap_q;
  end

  assign PERIOD = period_q;
`endif

endmodule

// File: tb/tb_pulse_receiver.sv
// Directed bench for pulse_receiver: acquisition, lock, missed pulse, CLR_ERR, EN drop,
// counter saturation (CW=4 instance) and asynchronous reset.
module tb_pulse_receiver;

  logic        clk;
  logic        rst_n;
  logic        en, pin, clr;
  logic        seen, locked, err;
  logic [15:0] cnt;
  logic        en2, pin2, clr2;
  logic        seen2, locked2, err2;
  logic [3:0]  cnt2;
`ifdef PULSE_RX_PERIOD_OUT_EN
  logic [7:0]  period, period2;
`endif

  int checks   = 0;
  int failures = 0;

  pulse_receiver dut (
    .CLK(clk), .RSTN(rst_n), .EN(en), .PULSE_IN(pin), .CLR_ERR(clr),
    .PULSE_SEEN(seen), .LOCKED(locked), .ERR(err),
`ifdef PULSE_RX_PERIOD_OUT_EN
    .PULSE_CNT(cnt), .PERIOD(period)
`else
    .PULSE_CNT(cnt)
`endif
  );

  pulse_receiver #(.CW(4)) dut4 (
    .CLK(clk), .RSTN(rst_n), .EN(en2), .PULSE_IN(pin2), .CLR_ERR(clr2),
    .PULSE_SEEN(seen2), .LOCKED(locked2), .ERR(err2),
`ifdef PULSE_RX_PERIOD_OUT_EN
    .PULSE_CNT(cnt2), .PERIOD(period2)
`else
    .PULSE_CNT(cnt2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // PULSE_IN low for p-1 edges, then high on the p-th edge (a rise p cycles after the last one).
  task automatic rise_after(input int p);
    for (int i = 1; i < p; i++) begin
      pin = 1'b0;
      tick();
    end
    pin = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; pin = 1'b0; clr = 1'b0;
    en2 = 1'b0; pin2 = 1'b0; clr2 = 1'b0;
    #12;
    check("rst_seen",   32'(seen),   32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err",    32'(err),    32'd0);
    check("rst_cnt",    32'(cnt),    32'd0);
`ifdef PULSE_RX_PERIOD_OUT_EN
    check("rst_period", 32'(period), 32'd0);
`endif
    rst_n = 1'b1;

    // Period-2 stream: SIDLE->SHUNT, then lock on the 5th rise.
    en = 1'b1;
    tick();
    check("a_idle_locked", 32'(locked), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      pin = 1'b1;
      tick();
      check("a_seen_hi", 32'(seen),   32'd1);
      check("a_cnt",     32'(cnt),    32'(k));
      check("a_locked",  32'(locked), (k == 5) ? 32'd1 : 32'd0);
      check("a_err",     32'(err),    32'd0);
      pin = 1'b0;
      tick();
      check("a_seen_lo", 32'(seen),   32'd0);
    end
    check("a_locked_hold", 32'(locked), 32'd1);

    // Missed pulse: error two edges after the last rise.
    tick();
    check("b_err",    32'(err),    32'd1);
    check("b_locked", 32'(locked), 32'd0);
    check("b_cnt",    32'(cnt),    32'd5);
    tick();
    pin = 1'b1;
    tick();
    check("b_serr_seen", 32'(seen), 32'd0);
    check("b_serr_cnt",  32'(cnt),  32'd5);
    check("b_serr_err",  32'(err),  32'd1);
    pin = 1'b0;
    tick();
    pin = 1'b1; clr = 1'b1;
    tick();
    check("b_clr_err",    32'(err),    32'd0);
    check("b_clr_cnt",    32'(cnt),    32'd0);
    check("b_clr_seen",   32'(seen),   32'd0);
    check("b_clr_locked", 32'(locked), 32'd0);
    clr = 1'b0;

    // From SHUNT: periods 2 | 2,2,3,2,2,2,2 -> lock only on the 4th good period after the 3.
    rise_after(2);
    check("c_r1_locked", 32'(locked), 32'd0);
    rise_after(2);
    rise_after(2);
    rise_after(3);
    check("c_r4_locked", 32'(locked), 32'd0);
`ifdef PULSE_RX_PERIOD_OUT_EN
    check("c_period3", 32'(period), 32'd3);
`endif
    rise_after(2);
`ifdef PULSE_RX_PERIOD_OUT_EN
    check("c_period2", 32'(period), 32'd2);
`endif
    rise_after(2);
    rise_after(2);
    check("c_r7_locked", 32'(locked), 32'd0);
    rise_after(2);
    check("c_r8_locked", 32'(locked), 32'd1);
    check("c_r8_cnt",    32'(cnt),    32'd8);
    check("c_r8_err",    32'(err),    32'd0);

    // CLR_ERR while locked clears only the count, and beats the increment.
    clr = 1'b1;
    rise_after(2);
    check("c_clr_cnt",    32'(cnt),    32'd0);
    check("c_clr_locked", 32'(locked), 32'd1);
    check("c_clr_seen",   32'(seen),   32'd1);
    clr = 1'b0;

    // EN dropped one cycle: unlock without error, relock after 1+LOCK_CNT rises.
    en = 1'b0; pin = 1'b0;
    tick();
    check("d_en_locked", 32'(locked), 32'd0);
    check("d_en_err",    32'(err),    32'd0);
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      rise_after(2);
      check("d_relock", 32'(locked), (k == 5) ? 32'd1 : 32'd0);
    end
    check("d_err", 32'(err), 32'd0);
    check("d_cnt", 32'(cnt), 32'd5);

    // CW=4 instance: saturation at 15. Main DUT sees no pulses and drops into SERR.
    pin = 1'b0;
    en2 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      pin2 = 1'b1;
      tick();
      check("f_cnt4", 32'(cnt2), (i < 15) ? 32'(i) : 32'd15);
      pin2 = 1'b0;
      tick();
    end
    check("f_main_err", 32'(err), 32'd1);
    pin2 = 1'b1;
    tick();
    check("f_seen4", 32'(seen2), 32'd1);
    check("f_sat4",  32'(cnt2),  32'd15);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("g_arst_seen4",   32'(seen2),   32'd0);
    check("g_arst_cnt4",    32'(cnt2),    32'd0);
    check("g_arst_locked4", 32'(locked2), 32'd0);
    check("g_arst_err4",    32'(err2),    32'd0);
    check("g_arst_err",     32'(err),     32'd0);
    check("g_arst_cnt",     32'(cnt),     32'd0);
    check("g_arst_locked",  32'(locked),  32'd0);

    // PULSE_IN already high at release counts as a rise on the first edge.
    pin = 1'b1; en = 1'b1; clr = 1'b0;
    pin2 = 1'b0; en2 = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check("h_first_seen", 32'(seen),   32'd1);
    check("h_first_cnt",  32'(cnt),    32'd1);
    check("h_first_lock", 32'(locked), 32'd0);
    pin = 1'b0;
    tick();
    check("h_seen_lo", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
